// File: rtl/lsl_pkg.sv
// Shared constants and the per-bit stage shift helper for the pipelined LSL unit.
package lsl_pkg;

    localparam int   MAX_WIDTH = 64;
    localparam logic RESET_BIT = 1'b0;

    typedef logic [$clog2(MAX_WIDTH)-1:0] pos_t;

    function automatic int STAGES_OF(input int width);
        return $clog2(width);
    endfunction

    // Bit 'pos' of (data << 2^k) when sbit is set, else bit 'pos' of data.
    function automatic logic stage_shift(input logic [MAX_WIDTH-1:0] data,
                                         input logic                 sbit,
                                         input int                   k,
                                         input pos_t                 pos);
        int src;
        src = int'(pos) - (1 << k);
        if (!sbit)
            return data[pos];
        else if (src < 0)
            return 1'b0;
        else
            return data[pos_t'(src)];
    endfunction

endpackage

// File: rtl/lsl_pipe_if.sv
// Operand/result handshake bundle for lsl_pipe; slave is the shifter side.
interface lsl_pipe_if #(parameter int WIDTH = 8);
  import lsl_pkg::*;

  localparam int STAGES = STAGES_OF(WIDTH);

  logic [WIDTH-1:0]  I;
  logic [STAGES-1:0] S;
  logic              I_VALID;
  logic              I_READY;
  logic [WIDTH-1:0]  O;
  logic              O_VALID;
  logic              O_READY;

  modport master (
    output I, S, I_VALID, O_READY,
    input  I_READY, O, O_VALID
  );

  modport slave (
    input  I, S, I_VALID, O_READY,
    output I_READY, O, O_VALID
  );

endinterface

// File: rtl/lsl_stage.sv
// One shifter stage: shift by 2^K or pass, then register; 1 cycle latency.
// Holds its word while downstream stalls; ready is the local !valid || downstream-ready.
module lsl_stage
  import lsl_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int K      = 0,
  localparam int STAGES = STAGES_OF(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  up_dat,
  input  logic [STAGES-1:0] up_sh,
  input  logic              up_vld,
  output logic              up_rdy,
  output logic [WIDTH-1:0]  dn_dat,
  output logic [STAGES-1:0] dn_sh,
  output logic              dn_vld,
  input  logic              dn_rdy
);

  logic [MAX_WIDTH-1:0] up_wide;
  logic [WIDTH-1:0]     nxt_dat;

  assign up_wide = MAX_WIDTH'(up_dat);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign nxt_dat[i] = stage_shift(up_wide, up_sh[K], K, pos_t'(i));
  end

  assign up_rdy = !dn_vld || dn_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      dn_dat <= {WIDTH{RESET_BIT}};
      dn_sh  <= '0;
      dn_vld <= 1'b0;
    end else if (up_rdy) begin
      dn_dat <= nxt_dat;
      dn_sh  <= up_sh;
      dn_vld <= up_vld;
    end
  end

endmodule

// File: rtl/lsl_pipe.sv
// Pipelined logical shift left, one stage per shift bit; latency STAGES, 1 word/cycle.
// Full backpressure: ready ripples combinationally from O_READY back to I_READY, no skid buffer.
module lsl_pipe
  import lsl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic        CLK,
  input logic        RESET,
  lsl_pipe_if.slave  bus
);

  localparam int STAGES = STAGES_OF(WIDTH);

  logic [WIDTH-1:0]  dat [STAGES+1];
  logic [STAGES-1:0] sh  [STAGES+1];
  logic              vld [STAGES+1];

  assign dat[0] = bus.I;
  assign sh[0]  = bus.S;
  assign vld[0] = bus.I_VALID;

  // Ready nets live per generate block so the chain is not one self-referencing array.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic rdy;
    logic dn_rdy;

    if (k == STAGES - 1) begin : g_last
      assign dn_rdy = bus.O_READY;
    end else begin : g_mid
      assign dn_rdy = g_stage[k+1].rdy;
    end

    lsl_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .clk    (CLK),
      .rst    (RESET),
      .up_dat (dat[k]),
      .up_sh  (sh[k]),
      .up_vld (vld[k]),
      .up_rdy (rdy),
      .dn_dat (dat[k+1]),
      .dn_sh  (sh[k+1]),
      .dn_vld (vld[k+1]),
      .dn_rdy (dn_rdy)
    );
  end

  assign bus.I_READY = g_stage[0].rdy;
  assign bus.O       = dat[STAGES];
  assign bus.O_VALID = vld[STAGES];

endmodule

// File: tb/tb_lsl_pipe.sv
// Bench for lsl_pipe at WIDTH=8: scenario tasks plus an in-order scoreboard on the output port.
module tb_lsl_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsl_pipe_if #(.WIDTH(8)) bus ();

  lsl_pipe #(.WIDTH(8)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] exp_q [$];

  // Scoreboard: push I<<S on every accepted word, pop on every consumed result.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (bus.O_VALID && bus.O_READY) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_order: got O=%h with no word outstanding", bus.O);
        end else begin
          e = exp_q.pop_front();
          if (bus.O !== e) begin
            n_bad++;
            $display("FAIL sb_order: got O=%h want %h", bus.O, e);
          end
        end
      end
      if (bus.I_VALID && bus.I_READY) begin
        e = bus.I << bus.S;
        exp_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.I_VALID = 1'b0;
    bus.O_READY = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.I_VALID = 1'b0;
    bus.O_READY = 1'b0;
    tick();
    tick();
    n_vec++;
    if (bus.O_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_ovalid: got %b want 0", bus.O_VALID); end
    n_vec++;
    if (bus.O !== 8'h00) begin n_bad++; $display("FAIL reset_o: got %h want 00", bus.O); end
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.I_READY !== 1'b1) begin n_bad++; $display("FAIL reset_iready: got %b want 1", bus.I_READY); end
  endtask

  task automatic test_basic();
    bus.O_READY = 1'b1;
    bus.I = 8'h5A;
    bus.S = 3'd3;
    bus.I_VALID = 1'b1;
    n_vec++;
    if (bus.I_READY !== 1'b1) begin n_bad++; $display("FAIL basic_iready: got %b want 1", bus.I_READY); end
    tick();
    bus.I_VALID = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      n_vec++;
      if (bus.O_VALID !== (c == 3)) begin
        n_bad++;
        $display("FAIL basic_ovalid: cycle %0d got %b want %b", c, bus.O_VALID, (c == 3));
      end
      if (c == 3) begin
        n_vec++;
        if (bus.O !== 8'hD0) begin n_bad++; $display("FAIL basic_o: got %h want d0", bus.O); end
      end
      tick();
    end
  endtask

  task automatic test_sweep();
    logic [7:0] tab [9] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h80};
    bus.O_READY = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      if (c < 8) begin
        bus.I = 8'hFF; bus.S = 3'(c); bus.I_VALID = 1'b1;
      end else if (c == 8) begin
        bus.I = 8'h01; bus.S = 3'd7; bus.I_VALID = 1'b1;
      end else begin
        bus.I_VALID = 1'b0;
      end
      if (c >= 3) begin
        n_vec++;
        if (bus.O_VALID !== (c < 12)) begin
          n_bad++;
          $display("FAIL sweep_ovalid: cycle %0d got %b want %b", c, bus.O_VALID, (c < 12));
        end
        if (c < 12) begin
          n_vec++;
          if (bus.O !== tab[c-3]) begin
            n_bad++;
            $display("FAIL sweep_o: cycle %0d got %h want %h", c, bus.O, tab[c-3]);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] tail [3] = '{8'h04, 8'h06, 8'h08};
    bus.O_READY = 1'b0;
    for (int w = 0; w < 3; w++) begin
      bus.I = 8'(w + 1); bus.S = 3'd1; bus.I_VALID = 1'b1;
      n_vec++;
      if (bus.I_READY !== 1'b1) begin n_bad++; $display("FAIL bp_accept: word %0d got I_READY=%b want 1", w, bus.I_READY); end
      tick();
    end
    bus.I = 8'h04; bus.S = 3'd1; bus.I_VALID = 1'b1;
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (bus.I_READY !== 1'b0) begin n_bad++; $display("FAIL bp_full: cycle %0d got I_READY=%b want 0", c, bus.I_READY); end
      n_vec++;
      if (bus.O_VALID !== 1'b1 || bus.O !== 8'h02) begin
        n_bad++;
        $display("FAIL bp_hold: cycle %0d got O_VALID=%b O=%h want 1/02", c, bus.O_VALID, bus.O);
      end
      tick();
    end
    bus.O_READY = 1'b1;
    #1;
    n_vec++;
    if (bus.I_READY !== 1'b1) begin n_bad++; $display("FAIL bp_release: got I_READY=%b want 1", bus.I_READY); end
    tick();
    bus.I_VALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (bus.O_VALID !== 1'b1 || bus.O !== tail[c]) begin
        n_bad++;
        $display("FAIL bp_drain: step %0d got O_VALID=%b O=%h want 1/%h", c, bus.O_VALID, bus.O, tail[c]);
      end
      tick();
    end
    n_vec++;
    if (bus.O_VALID !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got O_VALID=%b want 0", bus.O_VALID); end
  endtask

  task automatic test_back_to_back();
    bus.O_READY = 1'b0;
    for (int w = 0; w < 3; w++) begin
      bus.I = 8'(8'h21 + w); bus.S = 3'd0; bus.I_VALID = 1'b1;
      tick();
    end
    bus.I = 8'h11; bus.S = 3'd4; bus.I_VALID = 1'b1;
    bus.O_READY = 1'b1;
    #1;
    n_vec++;
    if (bus.I_READY !== 1'b1 || bus.O_VALID !== 1'b1 || bus.O !== 8'h21) begin
      n_bad++;
      $display("FAIL b2b_popush: got I_READY=%b O_VALID=%b O=%h want 1/1/21", bus.I_READY, bus.O_VALID, bus.O);
    end
    tick();
    bus.I_VALID = 1'b0;
    tick();
    tick();
    n_vec++;
    if (bus.O_VALID !== 1'b1 || bus.O !== 8'h10) begin
      n_bad++;
      $display("FAIL b2b_new: got O_VALID=%b O=%h want 1/10", bus.O_VALID, bus.O);
    end
    tick();
    n_vec++;
    if (bus.O_VALID !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got O_VALID=%b want 0", bus.O_VALID); end
  endtask

  task automatic test_reset_mid();
    bus.O_READY = 1'b1;
    bus.I = 8'h33; bus.S = 3'd1; bus.I_VALID = 1'b1;
    tick();
    bus.I = 8'h44; bus.S = 3'd2;
    tick();
    bus.I_VALID = 1'b0;
    rst = 1'b1;
    tick();
    n_vec++;
    if (bus.O_VALID !== 1'b0 || bus.O !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_mid_clear: got O_VALID=%b O=%h want 0/00", bus.O_VALID, bus.O);
    end
    exp_q.delete();
    rst = 1'b0;
    bus.I = 8'h07; bus.S = 3'd2; bus.I_VALID = 1'b1;
    #1;
    n_vec++;
    if (bus.I_READY !== 1'b1) begin n_bad++; $display("FAIL rst_mid_iready: got %b want 1", bus.I_READY); end
    tick();
    bus.I_VALID = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_vec++;
      if (bus.O_VALID !== (c == 3)) begin
        n_bad++;
        $display("FAIL rst_mid_ovalid: cycle %0d got %b want %b", c, bus.O_VALID, (c == 3));
      end
      if (c == 3) begin
        n_vec++;
        if (bus.O !== 8'h1C) begin n_bad++; $display("FAIL rst_mid_o: got %h want 1c", bus.O); end
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.I = 8'h00;
    bus.S = 3'd0;
    bus.I_VALID = 1'b0;
    bus.O_READY = 1'b0;
    test_reset();
    test_basic();
    idle(4);
    test_sweep();
    idle(4);
    test_backpressure();
    idle(4);
    test_back_to_back();
    idle(4);
    test_reset_mid();
    idle(4);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d words still outstanding, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lsl_pipe.md
Name: lsl_pipe

Overview:
Pipelined logical-shift-left unit: the left-shift counterpart of the team's combinational LSR mux-tree shifters, built for ice40 datapaths.
- One mux stage per shift-amount bit, each followed by a register stage.
- Valid/ready handshake on input and output with full backpressure.
- Throughput 1 word/cycle; latency STAGES cycles.
- Sits between an operand source and ALU writeback, so long shift mux trees never sit in one timing path.

Parameters:
- WIDTH, 8, data width in bits; must be a power of two, at least 2.
- STAGES, log2(WIDTH), number of pipeline stages and shift-amount width. Derived, not overridable.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- I  input  WIDTH  data to shift.
- S  input  STAGES  shift amount, 0..WIDTH-1.
- I_VALID  input  1  I/S valid this cycle.
- I_READY  output  1  unit accepts I/S this cycle.
- O  output  WIDTH  shifted result, I << S, zero-filled from the LSB.
- O_VALID  output  1  O holds a valid result.
- O_READY  input  1  downstream consumes O this cycle.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high.
- Registers: stage k (k = 0..STAGES-1) holds data D_k, the remaining shift bits, and valid V_k.
- Stage k function: shift its input left by 2^k when shift bit k is 1, otherwise pass through. Vacated LSBs are 0; bits shifted past the MSB are discarded. No wrap.
- Handshake: a transfer occurs on a cycle where valid and ready are both high. Data is captured on that CLK edge.
- Ready chain: ready_k = !V_k || ready_{k+1}, with ready_STAGES = O_READY, and I_READY = ready_0. The combinational path from O_READY to I_READY is permitted and intentional; no skid buffer.
- Stage advance: stage k loads from stage k-1 (stage 0 loads from I/S) when ready_k is high. V_k takes the upstream valid. When ready_k is low, the stage holds D_k and V_k unchanged.
- Outputs: O = D_{STAGES-1}, O_VALID = V_{STAGES-1}.
- Output stability: while O_VALID is high and O_READY is low, O is held stable until consumed.
- Latency: a word accepted in cycle t appears with O_VALID high in cycle t+STAGES when there is no stall.
- Ordering: results emerge strictly in acceptance order. No drop, no duplication.
- Reset values: all V_k = 0, all D_k = 0, hence O = 0 and O_VALID = 0. I_READY is 1 while RESET is low with the pipe empty.
- Reset mid-operation: all in-flight words are discarded, with no partial output. The first word can be accepted in the cycle after RESET deasserts.
- Full pipe: with all STAGES valid and O_READY = 0, I_READY = 0 and I_VALID is ignored (no capture).
- Simultaneous pop and push on a full pipe: when O_READY = 1, the whole pipe shifts and a new word is accepted in the same cycle.
- S = 0: passthrough, O = I after the latency.

Decomposition:
- Package lsl_pkg holds:
  - constant STAGES_OF(WIDTH), giving log2;
  - the reset data value (all zeros);
  - a helper function computing a stage shift (data, bit, k).
- One sub-module, lsl_stage, parameterised by WIDTH and stage index K. It contains:
  - the mux (shift by 2^K or pass), the data/shift/valid registers, and the local ready equation.
- lsl_pipe instantiates STAGES lsl_stage instances in a chain.

Test Plan:
All cases use WIDTH = 8.
1. Basic shift: RESET for 2 cycles, then I=0x5A, S=3, I_VALID=1, O_READY=1 for one cycle -> O=0xD0 with O_VALID=1 exactly 3 cycles later, and O_VALID=0 otherwise.
2. Sweep and edges: back-to-back I=0xFF with S=0..7, one per cycle, O_READY=1 -> outputs 0xFF, 0xFE, 0xFC, 0xF8, 0xF0, 0xE0, 0xC0, 0x80 on consecutive cycles starting at cycle 3. I=0x01, S=7 -> 0x80.
3. Backpressure: O_READY=0, then offer 4 words (0x01/S1, 0x02/S1, 0x03/S1, 0x04/S1) -> only 3 accepted, I_READY=0 from then on, O=0x02 held stable. Raise O_READY -> 0x02, 0x04, 0x06, then 0x08 once the 4th word is accepted, in order.
4. Simultaneous pop/push: pipe full, O_READY=1, I_VALID=1 with I=0x11, S=4 -> one output and one accept in the same cycle; 0x10 appears in order later.
5. Reset mid-flight: accept 2 words, assert RESET for 1 cycle -> O_VALID=0 and O=0 next cycle, and neither word ever appears. A new word accepted right after reset emerges with normal latency.
